// File: rtl/jericalla_issue_ctrl.sv
// Jericalla issue controller: FIFO-buffered issue onto main_bus with a 2-deep RAW scoreboard.
// Define JERICALLA_HAZARD_EN to compile in hazard stalls; otherwise words issue back-to-back.
module jericalla_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [16:0]      in_instr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [16:0]      main_bus,
    output logic             issue_valid,
    output logic             stall,
    output logic             busy,
    output logic [CNT_W-1:0] stall_count
);
    localparam int AW = $clog2(DEPTH);
`ifdef JERICALLA_HAZARD_EN
    localparam bit HazEn = 1'b1;
`else
    localparam bit HazEn = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

    state_t           state_q, state_d;
    logic [16:0]      mem_q [DEPTH];
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [16:0]      bus_q, bus_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;
    logic             s1_live_q, s1_live_d;
    logic             s2_live_q, s2_live_d;
    logic [4:0]       s1_wa_q, s1_wa_d;
    logic [4:0]       s2_wa_q, s2_wa_d;
    logic             empty, full, push, pop;
    logic             raw, hazard;
    logic [16:0]      head;

    function automatic logic writes_reg(input logic [16:0] w);
        return (w[16:15] != 2'b11) && (w[14:10] != 5'd0);
    endfunction

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign head  = mem_q[rptr_q];

    // live entries never hold WA=0, so r0 reads cannot match
    assign raw = (s1_live_q && (head[9:5] == s1_wa_q || head[4:0] == s1_wa_q))
              || (s2_live_q && (head[9:5] == s2_wa_q || head[4:0] == s2_wa_q));
    assign hazard = HazEn && !empty && raw;
    assign push   = in_valid && !full && !flush;
    assign pop    = !flush && !empty && !hazard;

    always_comb begin
        state_d   = IDLE;
        bus_d     = '0;
        scnt_d    = scnt_q;
        if (flush || empty) begin
            state_d = IDLE;
        end else if (hazard) begin
            state_d = STALL;
        end else begin
            state_d = RUN;
            bus_d   = head;
        end
        if (state_d == STALL && scnt_q != '1) begin
            scnt_d = scnt_q + CNT_W'(1);
        end

        s1_live_d = pop && writes_reg(head);
        s1_wa_d   = head[14:10];
        s2_live_d = s1_live_q;
        s2_wa_d   = s1_wa_q;

        rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
        wptr_d = push ? wptr_q + AW'(1) : wptr_q;
        cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        if (flush) begin
            rptr_d = '0;
            wptr_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rptr_q    <= '0;
            wptr_q    <= '0;
            cnt_q     <= '0;
            bus_q     <= '0;
            scnt_q    <= '0;
            s1_live_q <= 1'b0;
            s2_live_q <= 1'b0;
            s1_wa_q   <= '0;
            s2_wa_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            cnt_q     <= cnt_d;
            bus_q     <= bus_d;
            scnt_q    <= scnt_d;
            s1_live_q <= s1_live_d;
            s2_live_q <= s2_live_d;
            s1_wa_q   <= s1_wa_d;
            s2_wa_q   <= s2_wa_d;
            if (push) mem_q[wptr_q] <= in_instr;
        end
    end

    assign in_ready    = !full;
    assign main_bus    = bus_q;
    assign issue_valid = (state_q == RUN);
    assign stall       = HazEn && (state_q == STALL);
    assign busy        = !empty || s1_live_q || s2_live_q;
    assign stall_count = scnt_q;

endmodule
